fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 512x32 instruction memory (imem). imem has a 9-bit word address, a 32-bit write port and a registered read.
- Generates the PC and drives imem addr/din/wea. Absorbs imem's 1-cycle read latency and presents instr+pc to decode with a valid/ready handshake.
- Supports branch redirect and a boot-time program-load mode that writes imem through its write port.

Parameters:
- ADDR_W, 9, imem word-address width (PC is a word address)
- DATA_W, 32, instruction width
- RESET_PC, 0, first fetch address after load completes

Ports:
- clk  in  1  clock; rising edge
- rst  in  1  reset; asynchronous, active-high
- load_valid  in  1  load beat valid (LOAD state only)
- load_data  in  DATA_W  word to write at load_ptr
- load_done  in  1  end of load; enter RUN
- load_full  out  1  512 words written; further beats ignored
- redirect_valid  in  1  branch taken; kill the in-flight fetch
- redirect_pc  in  ADDR_W  branch target (word address)
- id_ready  in  1  decode accepts this cycle
- id_valid  out  1  id_instr/id_pc valid
- id_instr  out  DATA_W  instruction (= imem_dout, combinational)
- id_pc  out  ADDR_W  word address of id_instr
- imem_addr  out  ADDR_W  to imem addr
- imem_din  out  DATA_W  to imem din
- imem_wea  out  1  to imem wea
- imem_dout  in  DATA_W  from imem dout (mem[addr sampled at previous edge])

Behaviour:
- States: LOAD (reset state), RUN. LOAD->RUN on load_done. RUN has no exit except rst.
- Registers and reset values: state=LOAD, load_ptr=0, load_full=0, pc=RESET_PC, req_pc=0, req_valid=0.
- Outputs during reset: id_valid=0, imem_wea=0 (imem_wea is gated by !rst), imem_addr=0.
- LOAD:
  - imem_addr=load_ptr, imem_din=load_data, imem_wea=load_valid & !load_full.
  - On each write: load_ptr+1. A write at load_ptr=511 sets load_full=1 and load_ptr stays 511.
  - id_valid=0.
  - load_done with load_valid in the same cycle: the write happens, then transition.
  - At the transition edge: pc<=RESET_PC, req_valid<=0.
- RUN:
  - imem_wea=0, imem_din=0.
  - id_valid = req_valid & !redirect_valid; id_pc=req_pc; id_instr=imem_dout.
- RUN address select, priority order:
  1. redirect_valid: imem_addr=redirect_pc; req_pc<=redirect_pc, req_valid<=1, pc<=redirect_pc+1.
  2. Stall (req_valid & !id_ready): imem_addr=req_pc (re-read holds imem_dout stable); all registers hold.
  3. Else: imem_addr=pc; req_pc<=pc, req_valid<=1, pc<=pc+1.
- All PC arithmetic is mod 2^ADDR_W (511+1 -> 0).
- Latency:
  - First id_valid=1 appears after the 2nd rising edge following load_done sampled high.
  - After that, one instruction per cycle while id_ready=1.
  - After a redirect, the target is valid 1 cycle later.
- Redirect during a stall: redirect wins and the stalled instruction is dropped.
- Decode handshake: id_valid must not drop without a handshake, except on redirect or rst. id_instr and id_pc must stay stable while stalled.
- rst mid-RUN: outputs go to reset values immediately (async) and the block returns to LOAD. imem contents are untouched.

Decomposition:
- Shared package/header fetch_pkg: ADDR_W, DATA_W, state encodings ST_LOAD/ST_RUN, RESET_PC default.
- One sub-module, fetch_loader: load_ptr counter, load_full flag and wea generation for LOAD.
- fetch_unit holds the FSM, PC/request registers and address mux.
- Bench instantiates fetch_unit with imem behavioural model.

Test Plan:
- Load 0xE3A00001,0xE3A01002,0xE0802001,0xEAFFFFFE at 0..3, pulse load_done, id_ready=1 -> id_valid rises 2 edges later; id_pc 0,1,2,3 on consecutive cycles with matching id_instr.
- Stall: id_ready=0 for 3 cycles while id_pc=2 -> id_pc=2, id_instr=0xE0802001, imem_addr=2 held. Release -> next cycle id_pc=3.
- Redirect: redirect_valid with redirect_pc=0x100 while id_pc=5 -> id_valid=0 that cycle; next cycle id_pc=0x100, then 0x101.
- Redirect during stall, plus wrap: redirect_pc=511 with id_ready=0 -> next id_pc=511, then 0, then 1.
- Load overflow: 513 load_valid beats (data=index) -> load_full=1 after beat 512, no wea on beat 513, mem[0]=0, mem[511]=511.
- rst asserted mid-RUN while id_valid=1 -> id_valid=0 and imem_wea=0 before the next edge; block back in LOAD, load_ptr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and PC helpers for the instruction-fetch stage
// that sits directly upstream of the 512x32 imem.
package fetch_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [ADDR_W-1:0] LAST_ADDR        = '1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word-address increment; wraps 511 -> 0 by width.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the load port, redirect, decode handshake and imem bus.
// The master modport is the fetch-unit side; slave is the environment side.
interface fetch_if;
    import fetch_pkg::*;

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              load_full;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_din;
    logic              imem_wea;
    logic [DATA_W-1:0] imem_dout;

    modport master (
        input  load_valid, load_data, load_done, redirect_valid, redirect_pc,
               id_ready, imem_dout,
        output load_full, id_valid, id_instr, id_pc, imem_addr, imem_din, imem_wea
    );

    modport slave (
        output load_valid, load_data, load_done, redirect_valid, redirect_pc,
               id_ready, imem_dout,
        input  load_full, id_valid, id_instr, id_pc, imem_addr, imem_din, imem_wea
    );

endinterface

// File: rtl/fetch_loader.sv
// Boot-time program loader: walks load_ptr across imem and flags when all
// 512 words have been written, after which further beats are dropped.
module fetch_loader
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic              load_valid_i,
    output logic [ADDR_W-1:0] load_ptr_o,
    output logic              load_full_o,
    output logic              wea_o
);

    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              load_full_q, load_full_d;
    logic              write;

    assign write = active_i & load_valid_i & ~load_full_q;

    // The last slot sets full instead of advancing, so the pointer parks at 511.
    always_comb begin
        load_ptr_d  = load_ptr_q;
        load_full_d = load_full_q;
        if (write) begin
            if (load_ptr_q == LAST_ADDR) begin
                load_full_d = 1'b1;
            end else begin
                load_ptr_d = pc_inc(load_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ptr_q  <= '0;
            load_full_q <= 1'b0;
        end else begin
            load_ptr_q  <= load_ptr_d;
            load_full_q <= load_full_d;
        end
    end

    assign load_ptr_o  = load_ptr_q;
    assign load_full_o = load_full_q;
    assign wea_o       = write & ~rst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program-load sequencing, PC generation and the
// imem address mux, hiding imem's one-cycle read latency from decode.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_LOAD | boot: imem written from the load port, decode sees nothing
//   ST_RUN  | fetching: one word per cycle to decode, redirect/stall aware
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    fetch_if.master fetch_io
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;

    logic [ADDR_W-1:0] load_ptr;
    logic              loader_wea;

    fetch_loader u_loader (
        .clk          (clk),
        .rst          (rst),
        .active_i     (state_q == ST_LOAD),
        .load_valid_i (fetch_io.load_valid),
        .load_ptr_o   (load_ptr),
        .load_full_o  (fetch_io.load_full),
        .wea_o        (loader_wea)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOAD && fetch_io.load_done) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Address mux and request tracking. A stall re-presents req_pc so the
    // registered imem output keeps showing the same word.
    always_comb begin
        fetch_io.imem_addr = '0;
        fetch_io.imem_din  = '0;
        fetch_io.id_valid  = 1'b0;
        pc_d               = pc_q;
        req_pc_d           = req_pc_q;
        req_valid_d        = req_valid_q;
        unique case (state_q)
            ST_LOAD: begin
                fetch_io.imem_addr = load_ptr;
                fetch_io.imem_din  = fetch_io.load_data;
                if (fetch_io.load_done) begin
                    pc_d        = RESET_PC;
                    req_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                fetch_io.id_valid = req_valid_q & ~fetch_io.redirect_valid;
                if (fetch_io.redirect_valid) begin
                    fetch_io.imem_addr = fetch_io.redirect_pc;
                    req_pc_d           = fetch_io.redirect_pc;
                    req_valid_d        = 1'b1;
                    pc_d               = pc_inc(fetch_io.redirect_pc);
                end else if (req_valid_q && !fetch_io.id_ready) begin
                    fetch_io.imem_addr = req_pc_q;
                end else begin
                    fetch_io.imem_addr = pc_q;
                    req_pc_d           = pc_q;
                    req_valid_d        = 1'b1;
                    pc_d               = pc_inc(pc_q);
                end
            end
            default: ;
        endcase
    end

    assign fetch_io.imem_wea = loader_wea;
    assign fetch_io.id_instr = fetch_io.imem_dout;
    assign fetch_io.id_pc    = req_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a behavioural 512x32 imem: directed vector table,
// reset/overflow sequences, then randomized traffic against a stream model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;

    int checks   = 0;
    int failures = 0;

    fetch_if fio ();

    fetch_unit #(.RESET_PC(9'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (fio)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [512];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 512; k++) mem[k] <= '0;
        end else if (fio.imem_wea) begin
            mem[fio.imem_addr] <= fio.imem_din;
        end
        fio.imem_dout <= mem[fio.imem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        dn;
        logic        rv;
        logic [8:0]  rpc;
        logic        rdy;
        logic        e_valid;
        logic [8:0]  e_pc;
        logic [31:0] e_instr;
        logic [8:0]  e_addr;
        logic        e_wea;
    } vec_t;

    function automatic vec_t mk(logic lv, logic [31:0] ld, logic dn, logic rv,
                                logic [8:0] rpc, logic rdy, logic ev, logic [8:0] epc,
                                logic [31:0] ei, logic [8:0] ea, logic ew);
        vec_t v;
        v.lv = lv; v.ld = ld; v.dn = dn; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_addr = ea; v.e_wea = ew;
        return v;
    endfunction

    task automatic drive(input logic lv, input logic [31:0] ld, input logic dn,
                         input logic rv, input logic [8:0] rpc, input logic rdy);
        fio.load_valid     = lv;
        fio.load_data      = ld;
        fio.load_done      = dn;
        fio.redirect_valid = rv;
        fio.redirect_pc    = rpc;
        fio.id_ready       = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[20];
    logic       m_valid;
    logic [8:0] m_pc;
    logic       r_rv, r_rdy, e_valid;
    logic [8:0] r_rpc;

    initial begin
        tbl[0]  = mk(1, 32'hE3A00001, 0, 0, 0,     0, 0, 0,     0,            9'd0,   1);
        tbl[1]  = mk(1, 32'hE3A01002, 0, 0, 0,     0, 0, 0,     0,            9'd1,   1);
        tbl[2]  = mk(1, 32'hE0802001, 0, 0, 0,     0, 0, 0,     0,            9'd2,   1);
        tbl[3]  = mk(1, 32'hEAFFFFFE, 1, 0, 0,     0, 0, 0,     0,            9'd3,   1);
        tbl[4]  = mk(0, 0,            0, 0, 0,     1, 0, 0,     0,            9'd0,   0);
        tbl[5]  = mk(0, 0,            0, 0, 0,     1, 1, 9'd0,  32'hE3A00001, 9'd1,   0);
        tbl[6]  = mk(0, 0,            0, 0, 0,     1, 1, 9'd1,  32'hE3A01002, 9'd2,   0);
        tbl[7]  = mk(0, 0,            0, 0, 0,     0, 1, 9'd2,  32'hE0802001, 9'd2,   0);
        tbl[8]  = mk(0, 0,            0, 0, 0,     0, 1, 9'd2,  32'hE0802001, 9'd2,   0);
        tbl[9]  = mk(0, 0,            0, 0, 0,     0, 1, 9'd2,  32'hE0802001, 9'd2,   0);
        tbl[10] = mk(0, 0,            0, 0, 0,     1, 1, 9'd2,  32'hE0802001, 9'd3,   0);
        tbl[11] = mk(0, 0,            0, 0, 0,     1, 1, 9'd3,  32'hEAFFFFFE, 9'd4,   0);
        tbl[12] = mk(0, 0,            0, 0, 0,     1, 1, 9'd4,  32'h0,        9'd5,   0);
        tbl[13] = mk(0, 0,            0, 1, 9'h100,1, 0, 0,     0,            9'h100, 0);
        tbl[14] = mk(0, 0,            0, 0, 0,     1, 1, 9'h100,32'h0,        9'h101, 0);
        tbl[15] = mk(0, 0,            0, 0, 0,     1, 1, 9'h101,32'h0,        9'h102, 0);
        tbl[16] = mk(0, 0,            0, 1, 9'd511,0, 0, 0,     0,            9'd511, 0);
        tbl[17] = mk(0, 0,            0, 0, 0,     1, 1, 9'd511,32'h0,        9'd0,   0);
        tbl[18] = mk(0, 0,            0, 0, 0,     1, 1, 9'd0,  32'hE3A00001, 9'd1,   0);
        tbl[19] = mk(0, 0,            0, 0, 0,     1, 1, 9'd1,  32'hE3A01002, 9'd2,   0);

        rst = 1'b1;
        mem_clr = 1'b1;
        drive(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid",  32'(fio.id_valid),  32'd0);
        chk("rst_wea",       32'(fio.imem_wea),  32'd0);
        chk("rst_addr",      32'(fio.imem_addr), 32'd0);
        chk("rst_load_full", 32'(fio.load_full), 32'd0);
        mem_clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].lv, tbl[i].ld, tbl[i].dn, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_id_valid", i), 32'(fio.id_valid),  32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_addr", i),     32'(fio.imem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("vec%0d_wea", i),      32'(fio.imem_wea),  32'(tbl[i].e_wea));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_id_pc", i),    32'(fio.id_pc), 32'(tbl[i].e_pc));
                chk($sformatf("vec%0d_id_instr", i), fio.id_instr,   tbl[i].e_instr);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while decode holds a valid instruction.
        drive(0, 0, 0, 0, 0, 1);
        #2;
        chk("pre_rst_id_valid", 32'(fio.id_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_id_valid",  32'(fio.id_valid),  32'd0);
        chk("mid_rst_wea",       32'(fio.imem_wea),  32'd0);
        chk("mid_rst_addr",      32'(fio.imem_addr), 32'd0);
        chk("mid_rst_load_full", 32'(fio.load_full), 32'd0);
        @(negedge clk) rst = 1'b0;
        chk("mem_kept_0", mem[0], 32'hE3A00001);
        chk("mem_kept_3", mem[3], 32'hEAFFFFFE);

        // 513 load beats: the last one must be dropped.
        for (int i = 0; i < 513; i++) begin
            @(posedge clk);
            #1;
            drive(1, 32'(i), 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("ld%0d_addr", i),  32'(fio.imem_addr), (i < 512) ? 32'(i) : 32'd511);
            chk($sformatf("ld%0d_wea", i),   32'(fio.imem_wea),  (i < 512) ? 32'd1 : 32'd0);
            chk($sformatf("ld%0d_full", i),  32'(fio.load_full), (i < 512) ? 32'd0 : 32'd1);
            chk($sformatf("ld%0d_valid", i), 32'(fio.id_valid),  32'd0);
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        chk("ovf_mem0",   mem[0],   32'd0);
        chk("ovf_mem1",   mem[1],   32'd1);
        chk("ovf_mem256", mem[256], 32'd256);
        chk("ovf_mem511", mem[511], 32'd511);

        // Enter RUN, then random ready/redirect traffic against a stream model:
        // each presented word is the successor of the last accepted one, or a
        // redirect target, and its instruction equals its address (data=index).
        drive(0, 0, 1, 0, 0, 1);
        @(negedge clk);
        chk("done_id_valid", 32'(fio.id_valid), 32'd0);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_pc    = 9'd0;
        for (int c = 0; c < 400; c++) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 9) == 0);
            r_rpc = 9'($urandom_range(0, 511));
            drive(0, 0, 0, r_rv, r_rpc, r_rdy);
            @(negedge clk);
            e_valid = m_valid & ~r_rv;
            chk($sformatf("rnd%0d_id_valid", c), 32'(fio.id_valid), 32'(e_valid));
            chk($sformatf("rnd%0d_wea", c),      32'(fio.imem_wea), 32'd0);
            if (e_valid) begin
                chk($sformatf("rnd%0d_id_pc", c),    32'(fio.id_pc), 32'(m_pc));
                chk($sformatf("rnd%0d_id_instr", c), fio.id_instr,   32'(m_pc));
            end
            @(posedge clk);
            if (r_rv) begin
                m_valid = 1'b1;
                m_pc    = r_rpc;
            end else if (!(m_valid && !r_rdy)) begin
                m_pc    = m_valid ? 9'((32'(m_pc) + 1) % 512) : 9'd0;
                m_valid = 1'b1;
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
